// File: rtl/centering_unit.sv
// Two-pass mean removal: sums NSAMP vectors, divides once, then emits
// each vector minus the per-channel mean.
module centering_unit #(
  parameter int N_CH       = 4,
  parameter int DW         = 16,
  parameter int LOG2_NSAMP = 7
) (
  input  logic                     CLK_cen,
  input  logic                     RST_cen,
  input  logic                     GO_cen,
  input  logic                     En_mem1,
  input  logic [N_CH*DW-1:0]       Data_in,
  output logic                     CEN_busy,
  output logic [N_CH*(DW+1)-1:0]   Data_out,
  output logic                     Out_valid,
  output logic [N_CH*DW-1:0]       Mean_out,
  output logic                     Mean_valid,
  output logic                     Cen_done
);

  localparam int AW = DW + LOG2_NSAMP;
  localparam int OW = DW + 1;
  localparam logic [LOG2_NSAMP-1:0] CNT_LAST = '1;
  localparam logic [LOG2_NSAMP-1:0] CNT_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUM,
    S_DIV,
    S_SUB,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [LOG2_NSAMP-1:0]   cnt_q;
  logic signed [AW-1:0]    acc_q [N_CH];
  logic signed [AW-1:0]    acc_d [N_CH];
  logic [N_CH*DW-1:0]      mean_q;
  logic [N_CH*DW-1:0]      mean_d;
  logic [N_CH*OW-1:0]      diff_d;
  logic [N_CH*OW-1:0]      data_out_q;
  logic                    out_valid_q;
  logic                    mean_valid_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DW-1:0] x;
    logic [DW-1:0] m;
    assign x = Data_in[k*DW +: DW];
    assign m = mean_q[k*DW +: DW];
    assign acc_d[k] = acc_q[k] + $signed({{LOG2_NSAMP{x[DW-1]}}, x});
    // Top DW bits of the sum are exactly the floor shift, truncated
    assign mean_d[k*DW +: DW] = acc_q[k][AW-1 -: DW];
    assign diff_d[k*OW +: OW] = {x[DW-1], x} - {m[DW-1], m};
  end

  always_ff @(posedge CLK_cen) begin
    if (RST_cen) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      for (int k = 0; k < N_CH; k++) acc_q[k] <= '0;
      mean_q       <= '0;
      mean_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
    end else if (state_q != S_IDLE && !GO_cen) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mean_q       <= '0;
      mean_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (GO_cen) begin
            state_q <= S_SUM;
            cnt_q   <= '0;
            for (int k = 0; k < N_CH; k++) acc_q[k] <= '0;
          end
        end
        S_SUM: begin
          if (En_mem1) begin
            acc_q <= acc_d;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= S_DIV;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        S_DIV: begin
          mean_q       <= mean_d;
          mean_valid_q <= 1'b1;
          cnt_q        <= '0;
          state_q      <= S_SUB;
        end
        S_SUB: begin
          if (En_mem1) begin
            data_out_q  <= diff_d;
            out_valid_q <= 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        S_DONE: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CEN_busy   = (state_q == S_SUM) || (state_q == S_DIV) ||
                      (state_q == S_SUB);
  assign Cen_done   = (state_q == S_DONE);
  assign Data_out   = data_out_q;
  assign Out_valid  = out_valid_q;
  assign Mean_out   = mean_q;
  assign Mean_valid = mean_valid_q;

endmodule

// File: tb/tb_centering_unit.sv
// Randomized bench for centering_unit with a per-cycle reference model
// built from running sums, floor division and per-sample differences.
`timescale 1ns/1ps
module tb_centering_unit;

  localparam int N_CH = 4;
  localparam int DW   = 16;
  localparam int L2   = 7;
  localparam int NS   = 128;
  localparam int OW   = DW + 1;
  localparam int VW   = N_CH * DW;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic             en;
  logic [VW-1:0]    din;
  logic             busy;
  logic             ov;
  logic             mv;
  logic             done;
  logic [N_CH*OW-1:0] dout;
  logic [VW-1:0]    mout;

  always #5 clk = ~clk;

  centering_unit #(
    .N_CH(N_CH), .DW(DW), .LOG2_NSAMP(L2)
  ) dut (
    .CLK_cen(clk),
    .RST_cen(rst),
    .GO_cen(go),
    .En_mem1(en),
    .Data_in(din),
    .CEN_busy(busy),
    .Data_out(dout),
    .Out_valid(ov),
    .Mean_out(mout),
    .Mean_valid(mv),
    .Cen_done(done)
  );

  int checks = 0;
  int passes = 0;
  int ovcnt  = 0;
  bit armed  = 1'b0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_SUM, P_DIV, P_SUB, P_DONE} ph_e;
  ph_e    ph = P_IDLE;
  int     nacc;
  longint sums [N_CH];
  int     mean_m [N_CH];
  logic   e_busy, e_ov, e_mv, e_done;
  logic [N_CH*OW-1:0] e_dout;
  logic [VW-1:0]      e_mout;

  function automatic int chv(input logic [VW-1:0] v, input int k);
    logic signed [DW-1:0] s;
    s = v[k*DW +: DW];
    return int'(s);
  endfunction

  function automatic int fdiv(input longint s);
    longint q;
    q = s / NS;
    if ((s % NS) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ph = P_IDLE;
      e_ov = 1'b0;
      e_mv = 1'b0;
      e_dout = '0;
      e_mout = '0;
    end else begin
      e_ov = 1'b0;
      if (ph != P_IDLE && !go) begin
        ph = P_IDLE;
        e_mv = 1'b0;
        e_mout = '0;
      end else begin
        case (ph)
          P_IDLE: if (go) begin
            ph = P_SUM;
            nacc = 0;
            foreach (sums[k]) sums[k] = 0;
          end
          P_SUM: if (en) begin
            foreach (sums[k]) sums[k] += chv(din, k);
            nacc++;
            if (nacc == NS) ph = P_DIV;
          end
          P_DIV: begin
            foreach (sums[k]) begin
              mean_m[k] = fdiv(sums[k]);
              e_mout[k*DW +: DW] = DW'(mean_m[k]);
            end
            e_mv = 1'b1;
            nacc = 0;
            ph = P_SUB;
          end
          P_SUB: if (en) begin
            foreach (mean_m[k])
              e_dout[k*OW +: OW] = OW'(chv(din, k) - mean_m[k]);
            e_ov = 1'b1;
            nacc++;
            if (nacc == NS) ph = P_DONE;
          end
          default: ;
        endcase
      end
    end
    e_busy = (ph == P_SUM) || (ph == P_DIV) || (ph == P_SUB);
    e_done = (ph == P_DONE);
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", busy, e_busy);
      chk("out_valid", ov, e_ov);
      chk("mean_valid", mv, e_mv);
      chk("done", done, e_done);
      chk("mean_out", mout, e_mout);
      chk("data_out", dout, e_dout);
      if (ov === 1'b1) ovcnt++;
    end
  end

  // ---------------- stimulus ----------------
  logic [VW-1:0] vec [NS];

  function automatic logic [VW-1:0] mk(input int pat, input int i);
    logic [VW-1:0] v;
    v = {$urandom, $urandom};
    case (pat)
      0: for (int k = 0; k < N_CH; k++) v[k*DW +: DW] = 16'd100;
      1: begin
        v[0 +: DW]  = DW'(i - 64);
        v[DW +: DW] = 16'hFFFD;
      end
      2: v[0 +: DW] = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
      default: ;
    endcase
    return v;
  endfunction

  task automatic feed(input int n, input int stall);
    int i = 0;
    int c = 0;
    while (i < n && c < 4000) begin
      @(posedge clk); #1;
      c++;
      if (stall == 1) en = (c % 3 == 1);
      else if (stall == 2) en = ($urandom_range(0, 2) != 0);
      else en = 1'b1;
      din = en ? vec[i] : {$urandom, $urandom};
      if (en) i++;
    end
    chk("feed_bound", (i == n), 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic start_and_sum(input int pat, input int stall);
    for (int i = 0; i < NS; i++) vec[i] = mk(pat, i);
    go = 1'b1;
    en = 1'b1;
    din = {$urandom, $urandom};
    feed(NS, stall);
    din = {$urandom, $urandom};
    ovcnt = 0;
  endtask

  task automatic job(input int pat, input int stall, input int nsub);
    start_and_sum(pat, stall);
    feed(nsub, stall);
    if (nsub < NS) begin
      go = 1'b0;
      en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 1'b0);
      chk("abort_mv", mv, 1'b0);
      chk("abort_ovcnt", ovcnt, 10);
    end else begin
      en = 1'b1;
      din = {$urandom, $urandom};
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("hold_done", done, 1'b1);
      chk("hold_busy", busy, 1'b0);
      chk("ovcnt", ovcnt, NS);
      case (pat)
        0: begin
          chk("mean_const", mout, {4{16'd100}});
          chk("dout_const", dout, '0);
        end
        1: begin
          chk("mean_ramp0", mout[15:0], 16'hFFFF);
          chk("mean_ramp1", mout[31:16], 16'hFFFD);
          chk("dout_ramp0", dout[16:0], 17'd64);
          chk("dout_ramp1", dout[33:17], 17'd0);
        end
        2: begin
          chk("mean_ext", mout[15:0], 16'hFFFF);
          chk("dout_ext", dout[16:0], 17'h08000);
        end
        default: ;
      endcase
      @(posedge clk); #1;
      go = 1'b0;
      en = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_done", done, 1'b0);
      chk("idle_mout", mout, '0);
    end
  endtask

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    en  = 1'b0;
    din = '0;
    @(posedge clk); #1;
    armed = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dout", dout, '0);

    job(0, 0, NS);
    job(1, 0, NS);
    job(2, 0, NS);
    job(1, 1, NS);
    job(3, 2, NS);

    start_and_sum(1, 0);
    feed(50, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    go  = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_outs", {ov, mv, done, mout, dout}, '0);
    job(1, 0, NS);

    job(3, 0, 10);
    job(3, 1, NS);
    job(3, 2, NS);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/centering_unit.md
Name: centering_unit

Overview:
- Responder to the whitening controller's GO_cen / En_mem1 sequence; drives CEN_busy back to it.
- Two passes over the same NSAMP sample vectors from mem1:
  - SUM pass accumulates per-channel sums.
  - One DIV cycle forms per-channel means.
  - SUB pass emits mean-removed samples toward mem2 / the covariance unit.
- Sits between mem1 and mem2/cov in the whitening datapath.

Parameters:
- N_CH, 4, number of channels packed per sample vector.
- DW, 16, signed two's-complement width of one channel sample.
- LOG2_NSAMP, 7, log2 of samples per pass (NSAMP = 128).

Ports:
- CLK_cen  in  1  block clock, rising edge.
- RST_cen  in  1  reset, synchronous, active-high.
- GO_cen  in  1  level enable from controller; low aborts and returns to IDLE.
- En_mem1  in  1  Data_in valid this cycle.
- Data_in  in  N_CH*DW  packed samples; channel k at bits [k*DW +: DW].
- CEN_busy  out  1  high while a centering job is in progress.
- Data_out  out  N_CH*(DW+1)  packed centered samples; channel k at [k*(DW+1) +: DW+1].
- Out_valid  out  1  Data_out valid.
- Mean_out  out  N_CH*DW  packed per-channel means, held after DIV.
- Mean_valid  out  1  high from the cycle after DIV until IDLE.
- Cen_done  out  1  high in DONE.

Behaviour:
- Reset (RST_cen=1 at a rising edge) forces:
  - state=IDLE, cnt=0, accumulators=0.
  - All outputs 0: CEN_busy, Out_valid, Mean_valid, Cen_done, Data_out, Mean_out.
- RST_cen has priority over GO_cen.
- Accumulators: N_CH signed registers, width DW+LOG2_NSAMP; no overflow is possible.
- States:
  - IDLE: CEN_busy=0. If GO_cen=1 → SUM, with cnt and accumulators cleared on that edge. Any En_mem1 in the entry cycle is ignored.
  - SUM: on each edge with En_mem1=1, acc[k] += sign-extended Data_in[k] and cnt++. When the accepted sample is number NSAMP (cnt==NSAMP-1 and En_mem1=1) → DIV, cnt=0. Cycles with En_mem1=0 are stalls.
  - DIV: one cycle, En_mem1 ignored. mean[k] = acc[k] >>> LOG2_NSAMP (arithmetic shift, floor toward −inf), truncated to DW bits, which is exact since |mean| ≤ max|x|. Mean_out is registered; Mean_valid=1 from the next cycle → SUB.
  - SUB: on each edge with En_mem1=1, Data_out[k] = sext(Data_in[k]) − sext(mean[k]) in DW+1 bits (exact, no saturation) and Out_valid=1 on the following cycle, so latency is 1 cycle. Out_valid=0 on cycles with no accepted input. After NSAMP accepted samples → DONE; the final Out_valid pulse occurs in the first DONE cycle.
  - DONE: CEN_busy=0, Cen_done=1, Mean_out/Mean_valid held, En_mem1 ignored. Stays until GO_cen=0, then → IDLE.
- CEN_busy=1 exactly in SUM, DIV and SUB.
- Abort: GO_cen=0 in any state except IDLE → IDLE on that edge. Outputs are cleared as in reset except Data_out, which holds its value; no partial output is flagged.
- Data_out holds its last value when Out_valid=0.
- cnt width is LOG2_NSAMP bits; it never wraps, because it is cleared on each pass transition.
- GO_cen held high continuously does not retrigger; DONE is terminal until GO_cen falls.

Test Plan:
- Reset mid-SUB: RST_cen=1 after 50 samples, then a fresh full job → CEN_busy=0 and all outputs 0 the cycle after reset; second job results identical to a clean run.
- Constant input: all channels = 100 for 128 samples in both passes → Mean_out = 100 per channel; 128 Out_valid pulses, all Data_out = 0; Cen_done=1 after the last.
- Ramp with negatives: ch0 = i−64 (i=0..127), ch1 = −3 constant → mean0 = floor(−64/128) = −1, so Data_out ch0 = i−63; mean1 = −3, Data_out ch1 = 0. Floor rounding checked.
- Extremes: ch0 alternating −32768/+32767 → sum −64, mean −1 → outputs −32767 and 32768, fitting in 17 bits with no wrap.
- Stalls: En_mem1 toggled 1,0,0,1… in both passes → counts only accepted samples; means and output sequence match the stall-free run; Out_valid exactly 1 cycle after each accepted SUB sample.
- Abort / retrigger: GO_cen dropped during SUB after 10 outputs → IDLE next edge, CEN_busy=0, Mean_valid=0. Then GO_cen held high through DONE → no second job until GO_cen toggles low then high.
